christmas_light_seq: RTL and testbench

//  Parametrised multi-mode LED pattern sequencer for the board's green/red LED banks.
//  A prescaler derives a pattern tick from CLOCK_50, and a mode FSM steps through five display modes.

---
 rtl/christmas_pkg.sv | 22 ++
 rtl/christmas_light_seq_if.sv | 12 +
 rtl/tick_divider.sv | 27 ++
 rtl/christmas_light_seq.sv | 134 +++++++++++++
 tb/tb_christmas_light_seq.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/christmas_pkg.sv
// Shared definitions for the LED pattern sequencer: mode codes and pattern helpers.
package christmas_pkg;

    localparam int MODE_W = 3;

    localparam logic [MODE_W-1:0] MODE_BLINK_G  = 3'd0;
    localparam logic [MODE_W-1:0] MODE_BLINK_R  = 3'd1;
    localparam logic [MODE_W-1:0] MODE_BLINK_RG = 3'd2;
    localparam logic [MODE_W-1:0] MODE_CHASE    = 3'd3;
    localparam logic [MODE_W-1:0] MODE_ALT      = 3'd4;

    // Even-bits mask (bit0, bit2, ...) for banks up to 64 LEDs; callers size-cast.
    function automatic logic [63:0] alt_init(input int n);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 64; i += 2) begin
            if (i < n) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/christmas_light_seq_if.sv
// Board-side pin bundle: pushbuttons in, LED banks and mode code out.
interface christmas_light_seq_if #(
    parameter int NUM_LEDS = 8
);
    logic [2:0]          KEY;
    logic [NUM_LEDS-1:0] LEDG;
    logic [NUM_LEDS-1:0] LEDR;
    logic [2:0]          MODE;

    modport master (output KEY, input LEDG, input LEDR, input MODE);
    modport slave  (input KEY, output LEDG, output LEDR, output MODE);
endinterface

// File: rtl/tick_divider.sv
// Free-running prescaler: one-cycle tick every DIV enabled cycles, holds while disabled.
module tick_divider #(
    parameter int DIV = 25000000
) (
    input  logic CLOCK_50,
    input  logic RESET,
    input  logic en,
    input  logic clr,
    output logic tick
);
    localparam int CNT_W = $clog2(DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count_q;

    assign tick = en & (count_q == LAST);

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (en) begin
            count_q <= tick ? '0 : count_q + CNT_W'(1);
        end
    end
endmodule

// File: rtl/christmas_light_seq.sv
// Multi-mode LED pattern sequencer: key sync/edge detect, mode FSM, pattern and output registers.
module christmas_light_seq
    import christmas_pkg::*;
#(
    parameter int NUM_LEDS       = 8,
    parameter int TICK_DIV       = 25000000,
    parameter int STEPS_PER_MODE = 6
) (
    input  logic                   CLOCK_50,
    input  logic                   RESET,
    christmas_light_seq_if.slave   bus
);
    localparam int STEP_W = $clog2(STEPS_PER_MODE + 1);
    localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEPS_PER_MODE - 1);
    localparam logic [NUM_LEDS-1:0] ALT_INIT  = NUM_LEDS'(alt_init(NUM_LEDS));
    localparam logic [NUM_LEDS-1:0] CHASE_INIT = NUM_LEDS'(1);

    logic [2:0] key_s1_q, key_s2_q, key_prev_q;
    logic [2:0] key_pulse;

    // Per-button 2-FF synchroniser plus one history flop for falling-edge detection.
    for (genvar gi = 0; gi < 3; gi++) begin : g_key
        always_ff @(posedge CLOCK_50 or posedge RESET) begin
            if (RESET) begin
                key_s1_q[gi]   <= 1'b1;
                key_s2_q[gi]   <= 1'b1;
                key_prev_q[gi] <= 1'b1;
            end else begin
                key_s1_q[gi]   <= bus.KEY[gi];
                key_s2_q[gi]   <= key_s1_q[gi];
                key_prev_q[gi] <= key_s2_q[gi];
            end
        end
        assign key_pulse[gi] = key_prev_q[gi] & ~key_s2_q[gi];
    end

    logic [MODE_W-1:0]   mode_q;
    logic [NUM_LEDS-1:0] pat_q;
    logic [STEP_W-1:0]   step_q;
    logic                paused_q, auto_q;
    logic                tick, advance;
    logic [MODE_W-1:0]   succ_mode;
    logic [NUM_LEDS-1:0] entry_pat, stepped_pat;

    tick_divider #(.DIV(TICK_DIV)) u_tick_divider (
        .CLOCK_50 (CLOCK_50),
        .RESET    (RESET),
        .en       (~paused_q),
        .clr      (advance),
        .tick     (tick)
    );

    // A manual press and an auto-advance in the same cycle collapse into one advance.
    assign advance = key_pulse[0] | (tick & auto_q & (step_q == STEP_LAST));

    always_comb begin
        succ_mode = MODE_BLINK_R;
        case (mode_q)
            MODE_BLINK_G:  succ_mode = MODE_BLINK_R;
            MODE_BLINK_R:  succ_mode = MODE_BLINK_RG;
            MODE_BLINK_RG: succ_mode = MODE_CHASE;
            MODE_CHASE:    succ_mode = MODE_ALT;
            MODE_ALT:      succ_mode = MODE_BLINK_G;
            default:       succ_mode = MODE_BLINK_R;
        endcase
    end

    always_comb begin
        entry_pat = '0;
        case (succ_mode)
            MODE_CHASE: entry_pat = CHASE_INIT;
            MODE_ALT:   entry_pat = ALT_INIT;
            default:    entry_pat = '0;
        endcase
    end

    always_comb begin
        stepped_pat = ~pat_q;
        if (mode_q == MODE_CHASE) stepped_pat = {pat_q[NUM_LEDS-2:0], pat_q[NUM_LEDS-1]};
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            mode_q   <= MODE_BLINK_G;
            pat_q    <= '0;
            step_q   <= '0;
            paused_q <= 1'b0;
            auto_q   <= 1'b1;
        end else begin
            if (key_pulse[1]) paused_q <= ~paused_q;
            if (key_pulse[2]) auto_q   <= ~auto_q;
            if (advance) begin
                mode_q <= succ_mode;
                pat_q  <= entry_pat;
                step_q <= '0;
            end else if (tick) begin
                pat_q  <= stepped_pat;
                step_q <= step_q + STEP_W'(1);
            end
        end
    end

    logic [NUM_LEDS-1:0] led_g_d, led_r_d;
    logic [NUM_LEDS-1:0] led_g_q, led_r_q;
    logic [MODE_W-1:0]   mode_out_q;

    // Unreachable codes 5-7 display like BLINK_G.
    always_comb begin
        led_g_d = pat_q;
        led_r_d = '0;
        case (mode_q)
            MODE_BLINK_R:  begin led_g_d = '0;    led_r_d = pat_q;  end
            MODE_BLINK_RG: begin led_g_d = pat_q; led_r_d = pat_q;  end
            MODE_ALT:      begin led_g_d = pat_q; led_r_d = ~pat_q; end
            default:       begin led_g_d = pat_q; led_r_d = '0;     end
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge RESET) begin
        if (RESET) begin
            led_g_q    <= '0;
            led_r_q    <= '0;
            mode_out_q <= MODE_BLINK_G;
        end else begin
            led_g_q    <= led_g_d;
            led_r_q    <= led_r_d;
            mode_out_q <= mode_q;
        end
    end

    assign bus.LEDG = led_g_q;
    assign bus.LEDR = led_r_q;
    assign bus.MODE = mode_out_q;
endmodule

// File: tb/tb_christmas_light_seq.sv
// Directed + randomized bench for christmas_light_seq against a tick-count reference model.
module tb_christmas_light_seq;
    localparam int N        = 8;
    localparam int DIV      = 4;
    localparam int STEPS    = 3;
    localparam int STEP_MOD = 1 << $clog2(STEPS + 1);
    localparam logic [N-1:0] ALL = {N{1'b1}};

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    christmas_light_seq_if #(.NUM_LEDS(N)) bus ();

    christmas_light_seq #(
        .NUM_LEDS       (N),
        .TICK_DIV       (DIV),
        .STEPS_PER_MODE (STEPS)
    ) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .bus      (bus)
    );

    int    n_cmp = 0;
    int    n_bad = 0;
    string cur_tag = "init";

    // Reference state: mode number, ticks since entering it, divider phase, toggles, key history.
    int         m_mode, m_k, m_div;
    bit         m_paused, m_auto;
    logic [2:0] m_hist [3];
    logic [N-1:0] e_g, e_r;
    logic [2:0]   e_m;

    function automatic logic [N-1:0] even_mask();
        logic [N-1:0] m;
        m = '0;
        for (int i = 0; i < N; i += 2) m[i] = 1'b1;
        return m;
    endfunction

    // Pattern shown k ticks after entering a mode, mapped to {green, red}.
    function automatic logic [2*N-1:0] show(input int mode, input int k);
        logic [N-1:0] p, g, r;
        p = '0;
        case (mode)
            3:       p[k % N] = 1'b1;
            4:       p = (k % 2 == 1) ? ~even_mask() : even_mask();
            default: p = (k % 2 == 1) ? ALL : '0;
        endcase
        g = (mode == 1) ? '0 : p;
        r = (mode == 1 || mode == 2) ? p : (mode == 4) ? ~p : '0;
        return {g, r};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_k = 0; m_div = 0; m_paused = 0; m_auto = 1;
        for (int i = 0; i < 3; i++) m_hist[i] = 3'b111;
        e_g = '0; e_r = '0; e_m = 3'd0;
    endtask

    // One clock edge; a button level sampled at edge n acts at edge n+2.
    task automatic model_edge(input logic [2:0] s);
        logic [2:0] pulse;
        bit p0, tick, adv;
        {e_g, e_r} = show(m_mode, m_k);
        e_m   = 3'(m_mode);
        pulse = ~m_hist[1] & m_hist[2];
        p0    = m_paused;
        tick  = !p0 && (m_div == DIV - 1);
        adv   = pulse[0] || (tick && m_auto && ((m_k % STEP_MOD) == STEPS - 1));
        if (pulse[1]) m_paused = !m_paused;
        if (pulse[2]) m_auto   = !m_auto;
        if (adv) begin
            m_mode = (m_mode + 1) % 5; m_k = 0; m_div = 0;
        end else if (tick) begin
            m_k++; m_div = 0;
        end else if (!p0) begin
            m_div++;
        end
        m_hist[2] = m_hist[1]; m_hist[1] = m_hist[0]; m_hist[0] = s;
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge(bus.KEY);
        #1;
        n_cmp++;
        assert ({bus.LEDG, bus.LEDR, bus.MODE} === {e_g, e_r, e_m}) else begin
            n_bad++;
            $error("FAIL %s: got G=%h R=%h M=%0d expected G=%h R=%h M=%0d",
                   cur_tag, bus.LEDG, bus.LEDR, bus.MODE, e_g, e_r, e_m);
        end
        $display("[%0t] %s G=%h R=%h M=%0d", $time, cur_tag, bus.LEDG, bus.LEDR, bus.MODE);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic press(input int b, input int hold);
        bus.KEY[b] = 1'b0;
        run(hold);
        bus.KEY[b] = 1'b1;
    endtask

    task automatic bound_check(input bit ok, input string what);
        n_cmp++;
        assert (ok) else begin
            n_bad++;
            $error("FAIL %s: wait bound expired, got 0 required 1", what);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #23;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        int budget;
        bus.KEY = 3'b111;
        model_reset();
        rst = 1'b1;
        #12;
        n_cmp++;
        assert ({bus.LEDG, bus.LEDR, bus.MODE} === '0) else begin
            n_bad++;
            $error("FAIL reset_state: got %h required 0", {bus.LEDG, bus.LEDR, bus.MODE});
        end
        @(negedge clk);
        rst = 1'b0;

        cur_tag = "free_run";
        run(40);

        cur_tag = "to_chase";
        budget = 0;
        while (m_mode != 3 && budget < 200) begin cyc(); budget++; end
        bound_check(m_mode == 3, "reach_chase");
        cur_tag = "chase_manual";
        press(2, 2);
        run(9 * DIV + 4);

        cur_tag = "to_alt";
        press(0, 2);
        budget = 0;
        while (m_mode != 4 && budget < 20) begin cyc(); budget++; end
        bound_check(m_mode == 4, "reach_alt");
        cur_tag = "alt_manual";
        run(2 * DIV + 2);
        press(0, 2);
        run(4);

        cur_tag = "pause";
        run(2);
        press(1, 2);
        run(20);
        press(1, 2);
        run(10);
        cur_tag = "auto_back";
        press(2, 2);
        run(30);

        cur_tag = "simul_adv";
        do_reset();
        budget = 0;
        while (!(m_mode == 0 && m_k == STEPS - 1 && m_div == 1) && budget < 100) begin
            cyc(); budget++;
        end
        bound_check(m_mode == 0 && m_k == STEPS - 1 && m_div == 1, "simul_setup");
        press(0, 2);
        run(6);
        n_cmp++;
        assert (bus.MODE === 3'd1) else begin
            n_bad++;
            $error("FAIL simul_mode: got %0d required 1", bus.MODE);
        end

        cur_tag = "async_rst";
        budget = 0;
        while (m_mode != 3 && budget < 200) begin cyc(); budget++; end
        bound_check(m_mode == 3, "reach_chase2");
        run(5);
        #2;
        rst = 1'b1;
        #1;
        n_cmp++;
        assert ({bus.LEDG, bus.LEDR, bus.MODE} === '0) else begin
            n_bad++;
            $error("FAIL async_rst: got %h required 0", {bus.LEDG, bus.LEDR, bus.MODE});
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cur_tag = "after_rst";
        run(20);

        cur_tag = "random";
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 9) == 0) press($urandom_range(0, 2), $urandom_range(1, 3));
            else cyc();
        end
        if (m_paused) begin press(1, 2); run(12); end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
